// File: rtl/router_arb_pkg.sv
// Shared types and constants for the router output-port arbiter.
package router_arb_pkg;

   localparam int unsigned N_REQ_DFLT = 4;
   localparam int unsigned SEL_W      = 2;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GRANT = 2'd1,
      GAP   = 2'd2
   } arb_state_e;

endpackage

// File: rtl/router_out_arb_if.sv
// Request/grant bundle between the input-port requesters and the output arbiter.
interface router_out_arb_if
   import router_arb_pkg::*;
#(
   parameter int unsigned N_REQ = N_REQ_DFLT
) ();

   logic [N_REQ-1:0] req;
   logic [N_REQ-1:0] o_grant;
   logic [SEL_W-1:0] o_sel;
   logic             o_busy;
   logic             o_timeout;

   modport master (
      input  req,
      output o_grant, o_sel, o_busy, o_timeout
   );

   modport slave (
      output req,
      input  o_grant, o_sel, o_busy, o_timeout
   );

endinterface

// File: rtl/rr_arb_pick.sv
// Combinational round-robin picker: first set req bit at or above ptr, else lowest set bit.
module rr_arb_pick
   import router_arb_pkg::*;
#(
   parameter int unsigned N_REQ = N_REQ_DFLT
) (
   input  logic [N_REQ-1:0] req,
   input  logic [SEL_W-1:0] ptr,
   output logic [N_REQ-1:0] gnt,
   output logic             valid
);

   always_comb begin
      gnt   = '0;
      valid = 1'b0;
      for (int unsigned i = 0; i < N_REQ; i++) begin
         if (!valid && req[i] && (SEL_W'(i) >= ptr)) begin
            gnt[i] = 1'b1;
            valid  = 1'b1;
         end
      end
      // wrap pass: only reached when nothing at or above ptr is requesting
      for (int unsigned i = 0; i < N_REQ; i++) begin
         if (!valid && req[i]) begin
            gnt[i] = 1'b1;
            valid  = 1'b1;
         end
      end
   end

endmodule

// File: rtl/router_out_arb.sv
// Router output-port arbiter: round-robin, frame-hold, one dead cycle between frames.
// Optional grant watchdog with requester masking enabled by ROUTER_ARB_TIMEOUT_EN.
module router_out_arb
   import router_arb_pkg::*;
#(
   parameter int unsigned N_REQ = N_REQ_DFLT
`ifdef ROUTER_ARB_TIMEOUT_EN
   , parameter int unsigned TIMEOUT_CYC = 255
`endif
) (
   input  logic             clk,
   input  logic             reset_n,
   router_out_arb_if.master bus
);

   arb_state_e       state_q, state_d;
   logic [N_REQ-1:0] grant_q, grant_d;
   logic [SEL_W-1:0] sel_q, sel_d;
   logic [SEL_W-1:0] ptr_q, ptr_d;
   logic [N_REQ-1:0] elig;
   logic [N_REQ-1:0] pick_gnt;
   logic             pick_valid;
   logic [SEL_W-1:0] pick_idx;

`ifdef ROUTER_ARB_TIMEOUT_EN
   localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [N_REQ-1:0] mask_q, mask_d;
   logic             timeout_q, timeout_d;

   assign elig = bus.req & ~mask_q;
`else
   assign elig = bus.req;
`endif

   rr_arb_pick #(
      .N_REQ (N_REQ)
   ) u_pick (
      .req   (elig),
      .ptr   (ptr_q),
      .gnt   (pick_gnt),
      .valid (pick_valid)
   );

   always_comb begin
      pick_idx = '0;
      for (int unsigned i = 0; i < N_REQ; i++) begin
         if (pick_gnt[i]) pick_idx = pick_idx | SEL_W'(i);
      end
   end

   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      sel_d   = sel_q;
      ptr_d   = ptr_q;
`ifdef ROUTER_ARB_TIMEOUT_EN
      timeout_d = 1'b0;
      mask_d    = mask_q & bus.req;
      cnt_d     = '0;
`endif
      unique case (state_q)
         IDLE: begin
            if (pick_valid) begin
               state_d = GRANT;
               grant_d = pick_gnt;
               sel_d   = pick_idx;
               ptr_d   = (pick_idx == SEL_W'(N_REQ - 1)) ? '0 : pick_idx + 1'b1;
            end
         end
         GRANT: begin
            if (~|(bus.req & grant_q)) begin
               state_d = GAP;
               grant_d = '0;
               sel_d   = '0;
            end
`ifdef ROUTER_ARB_TIMEOUT_EN
            // a normal frame end wins over a watchdog hit on the same edge
            else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
               state_d   = GAP;
               grant_d   = '0;
               sel_d     = '0;
               timeout_d = 1'b1;
               mask_d    = mask_d | grant_q;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
`endif
         end
         GAP:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         grant_q <= '0;
         sel_q   <= '0;
         ptr_q   <= '0;
`ifdef ROUTER_ARB_TIMEOUT_EN
         cnt_q     <= '0;
         mask_q    <= '0;
         timeout_q <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         sel_q   <= sel_d;
         ptr_q   <= ptr_d;
`ifdef ROUTER_ARB_TIMEOUT_EN
         cnt_q     <= cnt_d;
         mask_q    <= mask_d;
         timeout_q <= timeout_d;
`endif
      end
   end

   assign bus.o_grant = grant_q;
   assign bus.o_sel   = sel_q;
   assign bus.o_busy  = (state_q == GRANT);
`ifdef ROUTER_ARB_TIMEOUT_EN
   assign bus.o_timeout = timeout_q;
`else
   assign bus.o_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_router_out_arb.sv
// Self-checking bench for router_out_arb: vector table, directed corner sequences,
// and random traffic against a cycle-level reference model.
module tb_router_out_arb;
   import router_arb_pkg::*;

   localparam int unsigned N = 4;
`ifdef ROUTER_ARB_TIMEOUT_EN
   localparam int unsigned TO = 8;
`endif

   logic clk     = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   router_out_arb_if #(.N_REQ(N)) bus ();

`ifdef ROUTER_ARB_TIMEOUT_EN
   router_out_arb #(.N_REQ(N), .TIMEOUT_CYC(TO)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );
`else
   router_out_arb #(.N_REQ(N)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );
`endif

   int total = 0;
   int bad   = 0;

   // reference model: who owns the port, dead cycles left, rotating start point
   int       m_owner;
   int       m_cool;
   int       m_ptr;
   int       m_hold;
   bit       m_to;
   bit [3:0] m_mask;

   typedef struct {
      logic [3:0] req;
      logic [3:0] grant;
      logic [1:0] sel;
      logic       busy;
   } vec_t;

   vec_t tbl[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_owner = -1;
      m_cool  = 0;
      m_ptr   = 0;
      m_hold  = 0;
      m_to    = 1'b0;
      m_mask  = '0;
   endtask

   task automatic model_edge(input logic [3:0] r);
      bit [3:0] old_mask;
      bit       found;
      int       c;
      old_mask = m_mask;
      m_to     = 1'b0;
      for (int i = 0; i < N; i++) if (!r[i]) m_mask[i] = 1'b0;
      if (m_owner >= 0) begin
         if (!r[m_owner]) begin
            m_owner = -1;
            m_cool  = 1;
         end
`ifdef ROUTER_ARB_TIMEOUT_EN
         else if (m_hold == TO) begin
            m_mask[m_owner] = 1'b1;
            m_owner = -1;
            m_cool  = 1;
            m_to    = 1'b1;
         end
`endif
         else m_hold++;
      end else if (m_cool > 0) begin
         m_cool--;
      end else begin
         found = 1'b0;
         for (int k = 0; k < N; k++) begin
            c = (m_ptr + k) % N;
            if (!found && r[c] && !old_mask[c]) begin
               found   = 1'b1;
               m_owner = c;
               m_ptr   = (c + 1) % N;
               m_hold  = 1;
            end
         end
      end
   endtask

   task automatic check_model(input string tag);
      logic [3:0] eg;
      logic [1:0] es;
      eg = (m_owner >= 0) ? 4'(1 << m_owner) : 4'b0000;
      es = (m_owner >= 0) ? 2'(m_owner) : 2'd0;
      check({tag, "_grant"},   32'(bus.o_grant),   32'(eg));
      check({tag, "_sel"},     32'(bus.o_sel),     32'(es));
      check({tag, "_busy"},    32'(bus.o_busy),    32'(m_owner >= 0));
      check({tag, "_timeout"}, 32'(bus.o_timeout), 32'(m_to));
   endtask

   task automatic cyc(input logic [3:0] r);
      bus.req = r;
      @(posedge clk);
      model_edge(r);
      #1;
      check_model("model");
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      bus.req = '0;
      model_reset();
      #1;
      check_model("reset");
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset_n = 1'b1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "time limit");
   end

   initial begin
      logic [3:0] r;
      int         order[$];
      int         exp_order[5];
      logic [3:0] prev;
      int         cnt_a, cnt_b, cnt_c;
      bit         flag;

      bus.req = '0;
      model_reset();
      do_reset();

      // single requester frame, dead cycles, then rotating grants
      for (int i = 0; i < 10; i++) tbl.push_back('{4'b0001, 4'b0001, 2'd0, 1'b1});
      tbl.push_back('{4'b0000, 4'b0000, 2'd0, 1'b0});
      tbl.push_back('{4'b0000, 4'b0000, 2'd0, 1'b0});
      tbl.push_back('{4'b0010, 4'b0010, 2'd1, 1'b1});
      tbl.push_back('{4'b0000, 4'b0000, 2'd0, 1'b0});
      tbl.push_back('{4'b0100, 4'b0000, 2'd0, 1'b0});
      tbl.push_back('{4'b0100, 4'b0100, 2'd2, 1'b1});
      tbl.push_back('{4'b1111, 4'b0100, 2'd2, 1'b1});
      tbl.push_back('{4'b0000, 4'b0000, 2'd0, 1'b0});
      for (int i = 0; i < tbl.size(); i++) begin
         cyc(tbl[i].req);
         check("tbl_grant", 32'(bus.o_grant), 32'(tbl[i].grant));
         check("tbl_sel",   32'(bus.o_sel),   32'(tbl[i].sel));
         check("tbl_busy",  32'(bus.o_busy),  32'(tbl[i].busy));
      end

      // all requesting, each winner releases for one cycle after 5 granted cycles
      do_reset();
      exp_order = '{0, 1, 2, 3, 0};
      prev = '0;
      for (int c = 0; c < 200 && order.size() < 5; c++) begin
         r = 4'b1111;
         if (m_owner >= 0 && m_hold >= 5) r[m_owner] = 1'b0;
         cyc(r);
         if (bus.o_grant != 4'b0000 && prev == 4'b0000) begin
            for (int i = 0; i < N; i++) if (bus.o_grant[i]) order.push_back(i);
         end
         prev = bus.o_grant;
      end
      check("rr_count", 32'(order.size()), 32'd5);
      for (int i = 0; i < order.size() && i < 5; i++)
         check("rr_order", 32'(order[i]), 32'(exp_order[i]));

      // no preemption mid-frame
      do_reset();
      cyc(4'b0100);
      check("hold_first", 32'(bus.o_grant), 32'b0100);
      for (int i = 0; i < 4; i++) begin
         cyc(4'b0101);
         check("hold_nopreempt", 32'(bus.o_grant), 32'b0100);
      end
      cyc(4'b0001);
      check("hold_gap", 32'(bus.o_grant), 32'b0000);
      cyc(4'b0001);
      check("hold_idle", 32'(bus.o_grant), 32'b0000);
      cyc(4'b0001);
      check("hold_next", 32'(bus.o_grant), 32'b0001);

      // asynchronous reset during a grant
      do_reset();
      cyc(4'b1000);
      check("ar_granted", 32'(bus.o_grant), 32'b1000);
      cyc(4'b1000);
      #2;
      reset_n = 1'b0;
      model_reset();
      #1;
      check("ar_grant_async", 32'(bus.o_grant), 32'b0000);
      check("ar_busy_async",  32'(bus.o_busy),  32'b0);
      @(negedge clk);
      reset_n = 1'b1;
      cyc(4'b1001);
      check("ar_ptr0", 32'(bus.o_grant), 32'b0001);

`ifdef ROUTER_ARB_TIMEOUT_EN
      // watchdog revokes port 1, port 3 takes over, port 1 masked until it releases
      do_reset();
      cnt_a = 0; cnt_b = 0; cnt_c = 0; flag = 1'b0;
      for (int i = 0; i < 20; i++) begin
         cyc(4'b1010);
         if (i == 0) check("wd_first", 32'(bus.o_grant), 32'b0010);
         if (i < 12 && bus.o_timeout) cnt_a++;
         if (bus.o_grant == 4'b1000) cnt_b = 1;
         if (flag && bus.o_grant == 4'b0010) cnt_c++;
         if (bus.o_timeout) flag = 1'b1;
      end
      check("wd_pulse",   32'(cnt_a), 32'd1);
      check("wd_port3",   32'(cnt_b), 32'd1);
      check("wd_masked1", 32'(cnt_c), 32'd0);
      cyc(4'b1000);
      cnt_c = 0;
      for (int i = 0; i < 12; i++) begin
         cyc(4'b1010);
         if (bus.o_grant == 4'b0010) cnt_c = 1;
      end
      check("wd_unmasked1", 32'(cnt_c), 32'd1);
`else
      // without the watchdog a long frame is never cut
      do_reset();
      cnt_a = 0; cnt_b = 0;
      for (int i = 0; i < 300; i++) begin
         cyc(4'b0010);
         if (bus.o_grant == 4'b0010) cnt_a++;
         if (bus.o_timeout) cnt_b++;
      end
      check("long_held",    32'(cnt_a), 32'd300);
      check("long_timeout", 32'(cnt_b), 32'd0);
`endif

      // random frame traffic with occasional resets
      do_reset();
      r = '0;
      for (int c = 0; c < 3000; c++) begin
         for (int i = 0; i < N; i++) if ($urandom_range(0, 7) == 0) r[i] = ~r[i];
         if ($urandom_range(0, 499) == 0) begin
            do_reset();
            r = '0;
         end
         cyc(r);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
